// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between an instruction and a data requester
//
// Purpose:
//   Grants the shared memory port to the instruction side (block fills) or the
//   data side (block fills or single-word writes). Arbitration is
//   non-preemptive with round-robin tie breaking. A fill issues 8 word reads
//   back to back and forwards each return combinationally, tagged with its
//   word index. After reset the block stays in QUIESCE for MEM_LAT cycles so
//   returns from an aborted fill are dropped.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_req, i_addr                 instruction-side fill request and address
//   d_req, d_wr, d_addr, d_wdata  data-side request, type (1 = write), address, write data
//   mem_addr, mem_en, mem_wr,     shared memory command (word aligned)
//   mem_wdata
//   mem_rdata, mem_rvalid         memory read return
//   fill_data, fill_word          returned word and its index in the 8-word block
//   i_data_valid, d_data_valid    fill_data/fill_word belong to the named side
//   i_done, d_done                one-cycle completion pulses
//   busy                          arbiter is not in IDLE

module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [15:0]           d_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_rvalid,
  output logic [15:0]           fill_data,
  output logic [2:0]            fill_word,
  output logic                  i_data_valid,
  output logic                  d_data_valid,
  output logic                  i_done,
  output logic                  d_done,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_DONE,
    S_QUIESCE
  } state_t;

  localparam logic       OWN_I     = 1'b0;
  localparam logic       OWN_D     = 1'b1;
  localparam logic [3:0] LP_Q_LAST = 4'(MEM_LAT - 1);

  state_t                r_state;
  state_t                w_next;
  logic                  r_owner;
  logic                  r_last;
  logic [ADDR_WIDTH-1:1] r_addr;
  logic [15:0]           r_wdata;
  logic [2:0]            r_issue_cnt;
  logic [2:0]            r_ret_cnt;
  logic [3:0]            r_q_cnt;

  logic                  w_grant_any;
  logic                  w_grant_d;
  logic                  w_ret;
  logic                  w_unused_bits;

  // Byte-select bit 0 never reaches the memory port.
  assign w_unused_bits = &{1'b0, i_addr[0], d_addr[0]};

  // D wins a tie only when I was granted last, which gives the alternation.
  assign w_grant_any = i_req || d_req;
  assign w_grant_d   = d_req && (!i_req || (r_last == OWN_I));

  // Returns count only while a fill is in flight; anything else is stale.
  assign w_ret = mem_rvalid && ((r_state == S_ISSUE) || (r_state == S_DRAIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_QUIESCE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_data    = '0;
    fill_word    = '0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    busy         = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (w_grant_any) begin
          w_next = (w_grant_d && d_wr) ? S_WRITE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = {r_addr[ADDR_WIDTH-1:4], r_issue_cnt, 1'b0};
        if (r_issue_cnt == 3'd7) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // With MEM_LAT >= 1 the last return always lands here, never in ISSUE.
        if (mem_rvalid && (r_ret_cnt == 3'd7)) begin
          w_next = S_DONE;
        end
      end
      S_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {r_addr, 1'b0};
        mem_wdata = r_wdata;
        w_next    = S_DONE;
      end
      S_DONE: begin
        i_done = (r_owner == OWN_I);
        d_done = (r_owner == OWN_D);
        w_next = S_IDLE;
      end
      S_QUIESCE: begin
        if (r_q_cnt == LP_Q_LAST) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_QUIESCE;
      end
    endcase

    if (w_ret) begin
      fill_data    = mem_rdata;
      fill_word    = r_ret_cnt;
      i_data_valid = (r_owner == OWN_I);
      d_data_valid = (r_owner == OWN_D);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= OWN_I;
      r_last      <= OWN_I;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_q_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_owner     <= w_grant_d;
            r_addr      <= w_grant_d ? d_addr[ADDR_WIDTH-1:1] : i_addr[ADDR_WIDTH-1:1];
            r_wdata     <= d_wdata;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
          end
        end
        S_ISSUE: begin
          r_issue_cnt <= r_issue_cnt + 3'd1;
        end
        S_DONE: begin
          r_last <= r_owner;
        end
        S_QUIESCE: begin
          r_q_cnt <= r_q_cnt + 4'd1;
        end
        default: begin
        end
      endcase
      if (w_ret) begin
        r_ret_cnt <= r_ret_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a transaction-timing reference model

module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int LAT = 4;
  localparam int TBL = 4200;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [15:0]   d_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic          mem_wr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;
  logic          mem_rvalid;
  logic [15:0]   fill_data;
  logic [2:0]    fill_word;
  logic          i_data_valid;
  logic          d_data_valid;
  logic          i_done;
  logic          d_done;
  logic          busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .i_done(i_done), .d_done(d_done), .busy(busy)
  );

  // Expected outputs per cycle; the all-zero default with busy=1 is what QUIESCE looks like.
  logic        e_idle  [TBL];
  logic        e_quiet [TBL];
  logic        e_en    [TBL];
  logic        e_wr    [TBL];
  logic [15:0] e_addr  [TBL];
  logic [15:0] e_wdata [TBL];
  logic        e_iv    [TBL];
  logic        e_dv    [TBL];
  logic [2:0]  e_word  [TBL];
  logic [15:0] e_data  [TBL];
  logic        e_idone [TBL];
  logic        e_ddone [TBL];

  // Memory contents as the model expects them, and as the environment actually serves them.
  logic [15:0] ref_mem [32768];
  logic [15:0] env_mem [32768];
  logic        pv [TBL];
  logic [15:0] pd [TBL];

  // Requesters: index 0 = I side, 1 = D side.
  logic        s_pend [2];
  logic        s_gnt  [2];
  logic        s_wr   [2];
  logic [15:0] s_addr [2];
  logic [15:0] s_wd   [2];
  int          s_done [2];
  int          s_drop [2];
  int          s_ok   [2];

  int   cyc;
  int   next_free;
  logic m_quiet;
  logic prev_rst;
  logic last_d;
  logic rand_mode;
  logic stale_en;
  int   force_drop;
  int   n_pass;
  int   n_fail;
  int   n_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_tbl(input int from, input int to);
    for (int c = from; c <= to && c < TBL; c++) begin
      e_idle[c] = 1'b0;  e_quiet[c] = 1'b0; e_en[c] = 1'b0;   e_wr[c] = 1'b0;
      e_addr[c] = '0;    e_wdata[c] = '0;   e_iv[c] = 1'b0;   e_dv[c] = 1'b0;
      e_word[c] = '0;    e_data[c] = '0;    e_idone[c] = 1'b0; e_ddone[c] = 1'b0;
    end
  endtask

  task automatic new_req(input int s, input logic [15:0] a, input logic w, input logic [15:0] wd);
    s_pend[s] = 1'b1;
    s_gnt[s]  = 1'b0;
    s_addr[s] = a;
    s_wr[s]   = (s == 1) ? w : 1'b0;
    s_wd[s]   = wd;
    s_drop[s] = BIG;
  endtask

  // Timeline of a granted transaction, straight from the fill/write timing rules.
  task automatic grant(input int s, input int g);
    int c;
    int v;
    s_gnt[s] = 1'b1;
    last_d   = (s == 1);
    if (force_drop >= 0) s_drop[s] = g + force_drop;
    else if (rand_mode && $urandom_range(0, 3) == 0) s_drop[s] = g + 1 + int'($urandom_range(0, 6));
    else s_drop[s] = BIG;
    if (s == 1 && s_wr[1]) begin
      e_en[g+1]    = 1'b1;
      e_wr[g+1]    = 1'b1;
      e_addr[g+1]  = s_addr[1] & 16'hFFFE;
      e_wdata[g+1] = s_wd[1];
      ref_mem[s_addr[1][15:1]] = s_wd[1];
      e_ddone[g+2] = 1'b1;
      s_done[s]    = g + 2;
      next_free    = g + 3;
    end else begin
      for (int k = 0; k < 8; k++) begin
        c         = g + 1 + k;
        v         = c + LAT;
        e_en[c]   = 1'b1;
        e_addr[c] = (s_addr[s] & 16'hFFF0) | 16'(2 * k);
        if (s == 0) e_iv[v] = 1'b1; else e_dv[v] = 1'b1;
        e_word[v] = 3'(k);
        e_data[v] = ref_mem[{s_addr[s][15:4], 3'(k)}];
      end
      if (s == 0) e_idone[g+9+LAT] = 1'b1; else e_ddone[g+9+LAT] = 1'b1;
      s_done[s] = g + 9 + LAT;
      next_free = g + 10 + LAT;
    end
  endtask

  task automatic step();
    logic rq [2];
    for (int s = 0; s < 2; s++) begin
      if (s_gnt[s] && cyc > s_done[s]) begin
        s_gnt[s]  = 1'b0;
        s_pend[s] = 1'b0;
        s_ok[s]   = cyc + 1 + int'($urandom_range(0, 3));
      end
      if (rand_mode && !s_pend[s] && cyc >= s_ok[s] && $urandom_range(0, 3) == 0)
        new_req(s, 16'($urandom), 1'($urandom), 16'($urandom));
      rq[s] = s_pend[s] && !(s_gnt[s] && cyc >= s_drop[s]);
    end
    if (rand_mode) rst = rst ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 499) == 0);

    i_req   = rq[0];
    d_req   = rq[1];
    i_addr  = (s_pend[0] && !s_gnt[0]) ? s_addr[0] : 16'($urandom);
    d_addr  = (s_pend[1] && !s_gnt[1]) ? s_addr[1] : 16'($urandom);
    d_wr    = (s_pend[1] && !s_gnt[1]) ? s_wr[1]   : 1'($urandom);
    d_wdata = (s_pend[1] && !s_gnt[1]) ? s_wd[1]   : 16'($urandom);

    if (cyc == next_free) m_quiet = 1'b0;
    e_quiet[cyc] = m_quiet;
    if (cyc == next_free) begin
      e_idle[cyc] = 1'b1;
      if (!rst && (rq[0] || rq[1])) begin
        if (rq[0] && rq[1]) grant(last_d ? 0 : 1, cyc);
        else grant(rq[1] ? 1 : 0, cyc);
      end else begin
        next_free = cyc + 1;
      end
    end
    if (rst) begin
      clear_tbl(cyc + 1, cyc + 40);
      next_free = BIG;
      m_quiet   = 1'b1;
      last_d    = 1'b0;
      for (int s = 0; s < 2; s++) begin
        if (s_gnt[s]) begin
          s_gnt[s]  = 1'b0;
          s_pend[s] = 1'b0;
          s_ok[s]   = cyc + 2;
        end
      end
    end else if (prev_rst) begin
      next_free = cyc + LAT;
    end
    prev_rst = rst;

    if (pv[cyc]) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pd[cyc];
    end else if (stale_en && e_idle[cyc] && $urandom_range(0, 2) == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'($urandom);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
    end

    @(negedge clk);
    if (cyc > 0) begin
      chk("busy",         busy,         !e_idle[cyc]);
      chk("mem_en",       mem_en,       e_en[cyc]);
      chk("mem_wr",       mem_wr,       e_wr[cyc]);
      chk("mem_addr",     mem_addr,     e_addr[cyc]);
      chk("mem_wdata",    mem_wdata,    e_wdata[cyc]);
      chk("i_data_valid", i_data_valid, e_iv[cyc]);
      chk("d_data_valid", d_data_valid, e_dv[cyc]);
      chk("i_done",       i_done,       e_idone[cyc]);
      chk("d_done",       d_done,       e_ddone[cyc]);
      if (e_iv[cyc] || e_dv[cyc] || e_quiet[cyc]) begin
        chk("fill_word", fill_word, e_word[cyc]);
        chk("fill_data", fill_data, e_data[cyc]);
      end
    end
    if (mem_en && !mem_wr && cyc + LAT < TBL) begin
      pv[cyc+LAT] = 1'b1;
      pd[cyc+LAT] = env_mem[mem_addr[15:1]];
    end
    if (mem_en && mem_wr) env_mem[mem_addr[15:1]] = mem_wdata;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_free(input int budget);
    int n;
    n = 0;
    while ((s_pend[0] || s_pend[1]) && n < budget) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int g;
    n_pass = 0; n_fail = 0; n_total = 0;
    cyc = 0; next_free = BIG; m_quiet = 1'b0; prev_rst = 1'b0; last_d = 1'b0;
    rand_mode = 1'b0; stale_en = 1'b0; force_drop = -1;
    clear_tbl(0, TBL - 1);
    for (int i = 0; i < TBL; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    for (int i = 0; i < 32768; i++) begin
      ref_mem[i] = 16'($urandom);
      env_mem[i] = ref_mem[i];
    end
    for (int s = 0; s < 2; s++) begin
      s_pend[s] = 1'b0; s_gnt[s] = 1'b0; s_wr[s] = 1'b0; s_addr[s] = '0; s_wd[s] = '0;
      s_done[s] = 0; s_drop[s] = BIG; s_ok[s] = 0;
    end
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset, then a tie in the first IDLE cycle: D write first, then I fill.
    repeat (3) step();
    rst = 1'b0;
    new_req(0, 16'h1236, 1'b0, 16'h0000);
    new_req(1, 16'h0043, 1'b1, 16'hBEEF);
    wait_free(80);
    repeat (2) step();

    // Second tie after I was last granted: D must win again.
    new_req(0, 16'h2000, 1'b0, 16'h0000);
    new_req(1, 16'h0100, 1'b0, 16'h0000);
    wait_free(80);
    repeat (2) step();

    // Reset in cycle 6 of an I fill while returns are still arriving.
    new_req(0, 16'h3456, 1'b0, 16'h0000);
    n = 0;
    while (!s_gnt[0] && n < 40) begin
      step();
      n++;
    end
    g = cyc - 1;
    while (cyc < g + 6) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    new_req(1, 16'h0700, 1'b0, 16'h0000);
    wait_free(80);

    // Stale returns in IDLE, then an I fill whose request drops in cycle 3.
    stale_en = 1'b1;
    repeat (10) step();
    force_drop = 3;
    new_req(0, 16'h0ABC, 1'b0, 16'h0000);
    wait_free(80);
    force_drop = -1;
    repeat (4) step();

    // Random traffic with occasional resets and stale returns.
    rand_mode = 1'b1;
    repeat (2000) step();
    rand_mode = 1'b0;
    rst = 1'b0;
    wait_free(200);
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 16, byte-address width of the memory port.
REQ-002 Parameter: MEM_LAT, 4, fixed number of cycles from a read issue to mem_rvalid; legal range 1-15.
REQ-003 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: i_req  input  1  instruction-side block-fill request; held high until i_done is sampled.
REQ-006 Port: i_addr  input  ADDR_WIDTH  instruction-side fill address; bits [3:0] are ignored.
REQ-007 Port: d_req  input  1  data-side request; held high until d_done is sampled.
REQ-008 Port: d_wr  input  1  data-side type: 1 = single-word write, 0 = block fill.
REQ-009 Port: d_addr  input  ADDR_WIDTH  data-side address; fill ignores bits [3:0], write ignores bit 0.
REQ-010 Port: d_wdata  input  16  data-side write data.
REQ-011 Port: mem_addr, mem_en, mem_wr, mem_wdata  output  ADDR_WIDTH/1/1/16  shared memory command, word-aligned (bit 0 always 0).
REQ-012 Port: mem_rdata, mem_rvalid  input  16/1  read return from memory.
REQ-013 Port: fill_data, fill_word  output  16/3  returned word and its index within the 8-word block.
REQ-014 Port: i_data_valid, d_data_valid  output  1/1  fill_data/fill_word are valid for the named side.
REQ-015 Port: i_done, d_done, busy  output  1/1/1  one-cycle completion pulses; busy = arbiter not in IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, DRAIN, WRITE, DONE and QUIESCE.
REQ-017 In IDLE, when exactly one request is high, that requester SHALL be granted; when both are high, the requester not granted last SHALL win, giving round-robin priority.
REQ-018 A grant SHALL latch the owner, the address and (for a write) d_wdata, and SHALL move the FSM to ISSUE (fill) or WRITE (write) on the next edge.
REQ-019 Arbitration SHALL be non-preemptive: requests are ignored outside IDLE, and dropping req mid-transaction SHALL NOT abort the transaction.
REQ-020 In ISSUE, the block SHALL drive mem_en=1 and mem_wr=0 for 8 consecutive cycles with mem_addr = {addr[ADDR_WIDTH-1:4], k[2:0], 1'b0} for k = 0..7.
REQ-021 After the 8th issue the FSM SHALL enter DRAIN, and from DRAIN SHALL enter DONE on the cycle after the 8th mem_rvalid.
REQ-022 A 3-bit return counter SHALL index returns: each mem_rvalid during ISSUE or DRAIN SHALL drive fill_data=mem_rdata, fill_word=count and the owner's data_valid in the same cycle (combinational).
REQ-023 mem_rvalid in IDLE, WRITE, DONE or QUIESCE SHALL be ignored: no data_valid and no counter change.
REQ-024 WRITE SHALL last exactly 1 cycle with mem_en=1, mem_wr=1, mem_addr={d_addr[ADDR_WIDTH-1:1],1'b0} and mem_wdata=latched data, then enter DONE.
REQ-025 DONE SHALL last 1 cycle, pulse the owner's done signal, record the owner as last-granted, and then enter IDLE.
REQ-026 Outside ISSUE and WRITE, mem_en, mem_wr, mem_addr and mem_wdata SHALL all be 0.
REQ-027 Fill timing with a grant in cycle 0: issues in cycles 1-8, word k valid in cycle 1+k+MEM_LAT, done in cycle 9+MEM_LAT, IDLE in cycle 10+MEM_LAT.
REQ-028 A requester that clears req on the edge at which done=1 is sampled SHALL NOT be re-granted, and a back-to-back grant to the other side SHALL be possible in the first IDLE cycle.

Reset
REQ-029 When rst is high at an edge, the block SHALL enter QUIESCE with counters 0 and last-granted = I, so that D wins the first tie.
REQ-030 During and after reset, all outputs SHALL be 0 except busy, which SHALL be 1 in QUIESCE.
REQ-031 QUIESCE SHALL last MEM_LAT cycles after rst deasserts so that in-flight returns from an aborted fill are discarded, and SHALL then enter IDLE.
REQ-032 rst asserted mid-transaction SHALL abort the transaction without a done pulse.

Verification (MEM_LAT=4, grant cycle = 0)
REQ-033 I fill, i_addr=0x1236 -> mem_addr 0x1230,0x1232,...,0x123E in cycles 1-8; i_data_valid in cycles 5-12 with fill_word 0..7; i_done in cycle 13.
REQ-034 D write, d_addr=0x0043, d_wdata=0xBEEF -> cycle 1: mem_en=1, mem_wr=1, mem_addr=0x0042, mem_wdata=0xBEEF; d_done in cycle 2; no data_valid.
REQ-035 i_req and d_req both high in the first IDLE cycle after reset -> D granted first; I granted in the IDLE cycle following d_done; on the next tie, D wins again.
REQ-036 rst in cycle 6 of an I fill, memory still returning words -> all outputs 0 and busy=1 through QUIESCE; stale mem_rvalid produces no data_valid; a new d_req is accepted afterwards with fill_word starting at 0.
REQ-037 mem_rvalid pulsed in IDLE, and i_req dropped in cycle 3 of a fill -> the IDLE pulse is ignored; the fill still returns all 8 words and pulses i_done in cycle 13.
